vector_pair_packer: RTL and testbench

Streaming front end for `inner_product`: accepts element pairs (a, b) one per cycle over a valid/ready handshake and assembles them into two packed N-element vectors. Each complete pair of vectors is presented with a valid/ready handshake in exactly the packed layout `inner_product` takes on `inp1`/`inp2`. A one-vector output holding register lets assembly of the next vector overlap the wait for the consumer, so sustained throughput is one vector per N cycles.

---
 rtl/inner_product_pkg.sv | 17 +
 rtl/vector_hold_reg.sv | 27 ++
 rtl/vector_pair_packer.sv | 117 +++++++++++
 tb/tb_vector_pair_packer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inner_product_pkg.sv
// Shared layout helpers for inner_product and its packer.
// Index width and element slot bit positions.
package inner_product_pkg;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int slot_lsb(input int k, input int dw);
    return k * dw;
  endfunction

  function automatic int slot_msb(input int k, input int dw);
    return (k + 1) * dw - 1;
  endfunction

endpackage

// File: rtl/vector_hold_reg.sv
// One-entry output holding register with valid/ready load and drain.
// Ports: clk, rst_n, load, d -> valid, q; ready drains the entry.
module vector_hold_reg #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vector_pair_packer.sv
// Packs (a, b) element pairs into N-element vectors for inner_product.
// Ports: in_* element handshake, out_* packed vector pair handshake.
module vector_pair_packer
  import inner_product_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW*N-1:0] out_a,
  output logic [DW*N-1:0] out_b,
  output logic          out_err
);

  localparam int IW = idx_w(N);
  localparam int VW = DW * N;
  localparam int HW = 2 * VW + 1;

  logic [IW-1:0] idx;
  logic          asm_full;
  logic          asm_err;
  logic [VW-1:0] asm_a;
  logic [VW-1:0] asm_b;

  logic          acc;
  logic          last_slot;
  logic          close;
  logic          close_err;
  logic          slot_free;
  logic          load;
  logic [VW-1:0] m_a;
  logic [VW-1:0] m_b;
  logic [HW-1:0] load_d;
  logic [HW-1:0] hold_q;

  assign in_ready = !asm_full;

  // Slots past idx stay zero in the buffer, so a short vector
  // needs no separate zero-fill step.
  always_comb begin
    acc       = in_valid && !asm_full;
    last_slot = (idx == IW'(N - 1));
    close     = acc && (last_slot || in_last);
    close_err = in_last ^ last_slot;
    slot_free = !out_valid || out_ready;
    m_a       = asm_a;
    m_b       = asm_b;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        m_a[slot_lsb(k, DW) +: DW] = in_a;
        m_b[slot_lsb(k, DW) +: DW] = in_b;
      end
    end
    load   = slot_free && (close || asm_full);
    load_d = asm_full ? {asm_err, asm_b, asm_a}
                      : {close_err, m_b, m_a};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      asm_full <= 1'b0;
      asm_err  <= 1'b0;
      asm_a    <= '0;
      asm_b    <= '0;
    end else if (asm_full) begin
      if (slot_free) begin
        asm_full <= 1'b0;
        asm_err  <= 1'b0;
        asm_a    <= '0;
        asm_b    <= '0;
      end
    end else if (acc) begin
      if (close) begin
        idx <= '0;
        if (slot_free) begin
          asm_a <= '0;
          asm_b <= '0;
        end else begin
          asm_full <= 1'b1;
          asm_err  <= close_err;
          asm_a    <= m_a;
          asm_b    <= m_b;
        end
      end else begin
        idx   <= idx + IW'(1);
        asm_a <= m_a;
        asm_b <= m_b;
      end
    end
  end

  vector_hold_reg #(
    .W(HW)
  ) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .d    (load_d),
    .ready(out_ready),
    .valid(out_valid),
    .q    (hold_q)
  );

  assign out_a   = hold_q[VW-1:0];
  assign out_b   = hold_q[2*VW-1:VW];
  assign out_err = hold_q[HW-1];

endmodule

// File: tb/tb_vector_pair_packer.sv
// Testbench for vector_pair_packer (N=4, DW=8).
// Directed scenarios plus randomized scoreboard streaming.
module tb_vector_pair_packer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int VW = N * DW;

  logic          tb_clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_a;
  logic [VW-1:0] out_b;
  logic          out_err;

  int total;
  int bad;
  int acc_cnt;

  logic [DW-1:0]   cur_a[$];
  logic [DW-1:0]   cur_b[$];
  logic [2*VW:0]   exp_q[$];
  logic [2*VW:0]   got_q[$];

  vector_pair_packer #(.N(N), .DW(DW)) dut (
    .clk      (tb_clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_err  (out_err)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Reference: collect elements, close on last or on N elements.
  task automatic model_push(input logic [DW-1:0] a,
                            input logic [DW-1:0] b,
                            input logic last);
    logic [VW-1:0] pa;
    logic [VW-1:0] pb;
    logic          err;
    cur_a.push_back(a);
    cur_b.push_back(b);
    if (last || cur_a.size() == N) begin
      pa = '0;
      pb = '0;
      for (int k = 0; k < cur_a.size(); k++) begin
        pa = pa + (VW'(cur_a[k]) << (DW * k));
        pb = pb + (VW'(cur_b[k]) << (DW * k));
      end
      err = (cur_a.size() != N) || !last;
      exp_q.push_back({err, pb, pa});
      cur_a.delete();
      cur_b.delete();
    end
  endtask

  task automatic tick();
    logic          ih;
    logic          oh;
    logic [2*VW:0] ov;
    ih = in_valid && in_ready;
    oh = out_valid && out_ready;
    ov = {out_err, out_b, out_a};
    @(posedge tb_clk);
    #1;
    if (ih) begin
      acc_cnt++;
      model_push(in_a, in_b, in_last);
    end
    if (oh) got_q.push_back(ov);
  endtask

  task automatic send(input logic [DW-1:0] a,
                      input logic [DW-1:0] b,
                      input logic last);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    for (int i = 0; i < 50; i++) begin
      ok = in_ready;
      tick();
      if (ok) break;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=%0b want=1", ok);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    out_ready = 1'b0;
  endtask

  task automatic clear_model();
    cur_a.delete();
    cur_b.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_flags got=%b%b want=01",
               out_valid, in_ready);
    end
    total++;
    if (out_a !== '0 || out_b !== '0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_data got=%h %h %b want=0",
               out_a, out_b, out_err);
    end
    out_ready = 1'b1;
    send(8'hAA, 8'hBB, 1'b0);
    send(8'hCC, 8'hDD, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_a !== '0 || out_b !== '0) begin
      bad++;
      $display("FAIL reset_mid got=%b%b %h %h want=01 0 0",
               out_valid, in_ready, out_a, out_b);
    end
    @(posedge tb_clk);
    #1 rst_n = 1'b1;
    send(8'h11, 8'h21, 1'b0);
    send(8'h12, 8'h22, 1'b0);
    send(8'h13, 8'h23, 1'b0);
    send(8'h14, 8'h24, 1'b1);
    total++;
    if (out_a !== 32'h14131211 || out_b !== 32'h24232221 ||
        out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_fresh got=%h %h %b want=14131211 24232221 0",
               out_a, out_b, out_err);
    end
    drain();
    clear_model();
  endtask

  task automatic test_nominal();
    out_ready = 1'b1;
    send(8'd1, 8'd5, 1'b0);
    send(8'd2, 8'd6, 1'b0);
    send(8'd3, 8'd7, 1'b0);
    send(8'd4, 8'd8, 1'b1);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL nominal_latency got=%b want=1", out_valid);
    end
    total++;
    if (out_a !== 32'h04030201 || out_b !== 32'h08070605 ||
        out_err !== 1'b0) begin
      bad++;
      $display("FAIL nominal_data got=%h %h %b want=04030201 08070605 0",
               out_a, out_b, out_err);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL nominal_drain got=%b want=0", out_valid);
    end
    clear_model();
  endtask

  task automatic test_short();
    out_ready = 1'b1;
    send(8'd9, 8'h31, 1'b0);
    send(8'd10, 8'h32, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_a !== 32'h00000A09 ||
        out_b !== 32'h00003231 || out_err !== 1'b1) begin
      bad++;
      $display("FAIL short_vec got=%b %h %h %b want=1 00000a09 00003231 1",
               out_valid, out_a, out_b, out_err);
    end
    drain();
    clear_model();
  endtask

  task automatic test_long();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(8'(8'h40 + i), 8'(8'h50 + i), 1'b0);
    total++;
    if (out_a !== 32'h43424140 || out_b !== 32'h53525150 ||
        out_err !== 1'b1) begin
      bad++;
      $display("FAIL long_vec got=%h %h %b want=43424140 53525150 1",
               out_a, out_b, out_err);
    end
    send(8'h77, 8'h88, 1'b1);
    total++;
    if (out_a !== 32'h00000077 || out_b !== 32'h00000088 ||
        out_err !== 1'b1) begin
      bad++;
      $display("FAIL long_next_slot0 got=%h %h %b want=77 88 1",
               out_a, out_b, out_err);
    end
    drain();
    clear_model();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(8'(8'h60 + i), 8'(8'h70 + i), (i == 3) || (i == 7));
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready_low got=%b want=0", in_ready);
    end
    tick();
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
        out_a !== 32'h63626160 || out_b !== 32'h73727170) begin
      bad++;
      $display("FAIL bp_hold got=%b %b %h %h want=0 1 63626160 73727170",
               in_ready, out_valid, out_a, out_b);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_a !== 32'h67666564 ||
        out_b !== 32'h77767574 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL bp_second got=%b %h %h %b want=1 67666564 77767574 0",
               out_valid, out_a, out_b, out_err);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_rise got=%b want=1", in_ready);
    end
    drain();
    total++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      bad++;
      $display("FAIL bp_count got=%0d want=%0d",
               got_q.size(), exp_q.size());
    end
    clear_model();
  endtask

  task automatic test_streaming();
    int drops;
    int start;
    int cyc;
    logic [2*VW:0] g;
    logic [2*VW:0] e;
    start = acc_cnt;
    cyc = 0;
    while (acc_cnt - start < 40 && cyc < 2000) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_a      = DW'($urandom);
      in_b      = DW'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 99) < 70);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (acc_cnt - start < 40) begin
      bad++;
      $display("FAIL stream_timeout got=%0d want=40",
               acc_cnt - start);
    end
    if (cur_a.size() != 0) send(8'hEE, 8'hFF, 1'b1);
    drops = 0;
    out_ready = 1'b1;
    start = acc_cnt;
    cyc = 0;
    while (acc_cnt - start < 20 && cyc < 500) begin
      if (!in_ready) drops++;
      in_valid = ($urandom_range(0, 99) < 70);
      in_a     = DW'($urandom);
      in_b     = DW'($urandom);
      in_last  = ($urandom_range(0, 3) == 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (cur_a.size() != 0) send(8'hE1, 8'hF1, 1'b1);
    for (int i = 0; i < 20 && out_valid; i++) tick();
    total++;
    if (drops != 0) begin
      bad++;
      $display("FAIL stream_ready_drop got=%0d want=0", drops);
    end
    total++;
    if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
      bad++;
      $display("FAIL stream_count got=%0d want=%0d",
               got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL stream_vec got=%h want=%h", g, e);
      end
    end
    clear_model();
  endtask

  initial begin
    total = 0;
    bad = 0;
    acc_cnt = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge tb_clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_backpressure();
    test_streaming();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
